pipeline_hazard_unit: RTL and testbench

Parametrised pipeline control block: arbitrates stall and bubble requests from I-cache misses, D-cache misses, multicycle ALU ops, load-use hazards and taken branches. It drives per-stage stall/flush vectors and the PC-advance enable for an in-order pipeline of configurable depth. It also keeps a wait-state FSM with a per-wait watchdog and a saturating stall-cycle performance counter.

---
 rtl/pipeline_hazard_unit_if.sv | 40 ++++
 rtl/pipeline_hazard_unit.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_unit_if.sv
// Control bundle between the pipeline datapath and the hazard unit.
// The datapath drives the condition inputs; the hazard unit returns the stall/flush controls.
interface pipeline_hazard_unit_if #(
  parameter int NUM_STAGES     = 5,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic                      icache_op_done;
  logic                      dcache_req;
  logic                      dcache_op_done;
  logic                      e_multicycle;
  logic                      alu_op_done;
  logic                      e_mem_read;
  logic                      e_reg_write;
  logic [REG_ADDR_WIDTH-1:0] e_rd;
  logic [REG_ADDR_WIDTH-1:0] d_rs1;
  logic [REG_ADDR_WIDTH-1:0] d_rs2;
  logic                      d_uses_rs1;
  logic                      d_uses_rs2;
  logic                      branch_taken;
  logic                      increase_pc;
  logic [NUM_STAGES-1:0]     stall;
  logic [NUM_STAGES-1:0]     flush;
  logic [CNT_WIDTH-1:0]      stall_cycles;
  logic                      timeout_err;

  modport master (
    output icache_op_done, dcache_req, dcache_op_done, e_multicycle, alu_op_done,
           e_mem_read, e_reg_write, e_rd, d_rs1, d_rs2, d_uses_rs1, d_uses_rs2,
           branch_taken,
    input  increase_pc, stall, flush, stall_cycles, timeout_err
  );

  modport slave (
    input  icache_op_done, dcache_req, dcache_op_done, e_multicycle, alu_op_done,
           e_mem_read, e_reg_write, e_rd, d_rs1, d_rs2, d_uses_rs1, d_uses_rs2,
           branch_taken,
    output increase_pc, stall, flush, stall_cycles, timeout_err
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Stall/flush arbiter for an in-order pipeline: prioritised hazard response, wait-state FSM
// with a per-wait watchdog, and a saturating count of cycles where the PC could not advance.
module pipeline_hazard_unit #(
  parameter int NUM_STAGES     = 5,
  parameter int EX_STAGE       = 2,
  parameter int MEM_STAGE      = 3,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT        = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_unit_if.slave hz
);

  typedef enum logic [1:0] {RUN, I_WAIT, D_WAIT, A_WAIT} state_t;

  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

  state_t                state, state_nxt;
  logic                  drop_fetch;
  logic [15:0]           wait_cnt;
  logic [16:0]           wait_inc;
  logic [CNT_WIDTH-1:0]  stall_cnt;
  logic                  timeout_q;

  logic                  d_miss, a_busy, load_use, branch, i_miss;
  logic                  branch_act, i_miss_act;
  logic [NUM_STAGES-1:0] stall_c, flush_c;
  logic                  inc_pc;

  assign d_miss   = hz.dcache_req & ~hz.dcache_op_done;
  assign a_busy   = hz.e_multicycle & ~hz.alu_op_done;
  assign load_use = hz.e_mem_read & hz.e_reg_write & (hz.e_rd != '0) &
                    ((hz.d_uses_rs1 & (hz.d_rs1 == hz.e_rd)) |
                     (hz.d_uses_rs2 & (hz.d_rs2 == hz.e_rd)));
  assign branch   = hz.branch_taken;
  assign i_miss   = ~hz.icache_op_done;

  // A branch shares the top slot with an I-cache miss: the redirect wins, the miss keeps waiting.
  assign branch_act = branch & ~d_miss & ~a_busy & ~load_use;
  assign i_miss_act = i_miss & ~d_miss & ~a_busy & ~load_use;

  // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
  always_comb begin
    stall_c = '0;
    flush_c = '0;
    inc_pc  = 1'b1;
    if (d_miss) begin
      inc_pc = 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        stall_c[s] = (s <= MEM_STAGE);
        flush_c[s] = (s == MEM_STAGE + 1);
      end
    end else if (a_busy) begin
      inc_pc = 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        stall_c[s] = (s <= EX_STAGE);
        flush_c[s] = (s == EX_STAGE + 1);
      end
    end else if (load_use) begin
      inc_pc = 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        stall_c[s] = (s < EX_STAGE);
        flush_c[s] = (s == EX_STAGE);
      end
    end else if (branch) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        flush_c[s] = (s >= 1) && (s <= EX_STAGE);
      end
    end else if (i_miss) begin
      inc_pc     = 1'b0;
      stall_c[0] = 1'b1;
      flush_c[1] = 1'b1;
    end
    if (drop_fetch) flush_c[1] = 1'b1;
  end

  always_comb begin
    state_nxt = RUN;
    if (d_miss) begin
      state_nxt = D_WAIT;
    end else if (a_busy) begin
      state_nxt = (state == D_WAIT) ? D_WAIT : A_WAIT;
    end else if (i_miss && (i_miss_act || state == I_WAIT)) begin
      state_nxt = I_WAIT;
    end
  end

  // Controls must reach the stage registers on the same edge, so they stay combinational;
  // reset forces every stage to a bubble and freezes the PC.
  assign hz.stall        = rst_n ? stall_c : '0;
  assign hz.flush        = rst_n ? flush_c : '1;
  assign hz.increase_pc  = rst_n & inc_pc;
  assign hz.stall_cycles = stall_cnt;
  assign hz.timeout_err  = timeout_q;

  assign wait_inc = {1'b0, wait_cnt} + 17'd1;

  // NOTE: all state is updated with non-blocking assignments so every register samples
  // pre-edge values, and all of it is cleared asynchronously so nothing outlives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      drop_fetch <= 1'b0;
      wait_cnt   <= '0;
      stall_cnt  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state || state == RUN) begin
        wait_cnt <= '0;
      end else if (wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 16'd1;
      end

      if (state != RUN && state_nxt == state && wait_inc >= TIMEOUT_L) begin
        timeout_q <= 1'b1;
      end

      // The line returning after a redirect belongs to the old path and must be discarded.
      if (hz.icache_op_done) begin
        drop_fetch <= 1'b0;
      end else if (branch_act && state == I_WAIT) begin
        drop_fetch <= 1'b1;
      end

      if (!inc_pc && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed-vector bench for pipeline_hazard_unit (5 stages, EX=2, MEM=3, watchdog limit 8).
module tb_pipeline_hazard_unit;

  localparam int NS  = 5;
  localparam int RAW = 5;
  localparam int CW  = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_sc   = 0;

  pipeline_hazard_unit_if #(.NUM_STAGES(NS), .REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)) hz ();

  pipeline_hazard_unit #(
    .NUM_STAGES(NS), .EX_STAGE(2), .MEM_STAGE(3),
    .REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW), .TIMEOUT(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hz.icache_op_done = 1'b1;
    hz.dcache_req     = 1'b0;
    hz.dcache_op_done = 1'b1;
    hz.e_multicycle   = 1'b0;
    hz.alu_op_done    = 1'b1;
    hz.e_mem_read     = 1'b0;
    hz.e_reg_write    = 1'b0;
    hz.e_rd           = '0;
    hz.d_rs1          = '0;
    hz.d_rs2          = '0;
    hz.d_uses_rs1     = 1'b0;
    hz.d_uses_rs2     = 1'b0;
    hz.branch_taken   = 1'b0;
  endtask

  // Called right after a falling edge with inputs applied: checks the combinational
  // controls, lets one rising edge pass, and returns on the next falling edge.
  task automatic cyc(input string tag, input logic [NS-1:0] es, input logic [NS-1:0] ef,
                     input logic ei);
    #1;
    check({tag, "/stall"}, 32'(hz.stall), 32'(es));
    check({tag, "/flush"}, 32'(hz.flush), 32'(ef));
    check({tag, "/inc_pc"}, 32'(hz.increase_pc), 32'(ei));
    @(posedge clk);
    if (!ei) exp_sc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    exp_sc = 0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst/flush", 32'(hz.flush), 32'h1f);
    check("rst/stall", 32'(hz.stall), 32'h0);
    check("rst/inc_pc", 32'(hz.increase_pc), 32'h0);
    check("rst/stall_cycles", hz.stall_cycles, 32'd0);
    check("rst/timeout_err", 32'(hz.timeout_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst", 5'b00000, 5'b00000, 1'b1);

    // Load-use variants.
    hz.e_mem_read = 1'b1; hz.e_reg_write = 1'b1; hz.e_rd = 5'd7;
    hz.d_rs2 = 5'd7; hz.d_uses_rs2 = 1'b1;
    cyc("lu_rs2", 5'b00011, 5'b00100, 1'b0);
    hz.e_rd = 5'd0; hz.d_rs2 = 5'd0;
    cyc("lu_x0", 5'b00000, 5'b00000, 1'b1);
    hz.e_rd = 5'd9; hz.d_rs1 = 5'd9; hz.d_uses_rs1 = 1'b1; hz.d_uses_rs2 = 1'b0;
    cyc("lu_rs1", 5'b00011, 5'b00100, 1'b0);
    hz.d_uses_rs1 = 1'b0;
    cyc("lu_unused", 5'b00000, 5'b00000, 1'b1);
    hz.d_uses_rs1 = 1'b1; hz.e_reg_write = 1'b0;
    cyc("lu_nowrite", 5'b00000, 5'b00000, 1'b1);

    // Priority ladder: D_MISS over A_BUSY over LOAD_USE over I_MISS.
    hz.e_reg_write = 1'b1; hz.icache_op_done = 1'b0;
    hz.e_multicycle = 1'b1; hz.alu_op_done = 1'b0;
    hz.dcache_req = 1'b1; hz.dcache_op_done = 1'b0;
    cyc("prio_d", 5'b01111, 5'b10000, 1'b0);
    hz.dcache_op_done = 1'b1;
    cyc("prio_a", 5'b00111, 5'b01000, 1'b0);
    hz.alu_op_done = 1'b1;
    cyc("prio_lu", 5'b00011, 5'b00100, 1'b0);
    idle();
    cyc("prio_idle", 5'b00000, 5'b00000, 1'b1);
    check("stall_cycles_model", hz.stall_cycles, 32'(exp_sc));

    // D-cache miss with a branch waiting in EX.
    do_reset();
    check("dmiss/sc_start", hz.stall_cycles, 32'd0);
    hz.dcache_req = 1'b1; hz.dcache_op_done = 1'b0; hz.branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) cyc($sformatf("dmiss%0d", i), 5'b01111, 5'b10000, 1'b0);
    check("dmiss/stall_cycles", hz.stall_cycles, 32'd4);
    hz.dcache_op_done = 1'b1;
    cyc("dmiss_branch", 5'b00000, 5'b00110, 1'b1);
    check("dmiss/sc_hold", hz.stall_cycles, 32'd4);
    idle();
    cyc("dmiss_idle", 5'b00000, 5'b00000, 1'b1);

    // Branch while waiting on an I-cache miss: stale line gets dropped.
    hz.icache_op_done = 1'b0;
    cyc("iw1", 5'b00001, 5'b00010, 1'b0);
    hz.branch_taken = 1'b1;
    cyc("iw2_branch", 5'b00000, 5'b00110, 1'b1);
    hz.branch_taken = 1'b0;
    cyc("iw3", 5'b00001, 5'b00010, 1'b0);
    hz.icache_op_done = 1'b1;
    cyc("iw4_drop", 5'b00000, 5'b00010, 1'b1);
    cyc("iw5_clear", 5'b00000, 5'b00000, 1'b1);

    // Multicycle ALU op.
    hz.e_multicycle = 1'b1; hz.alu_op_done = 1'b0;
    for (int i = 0; i < 6; i++) cyc($sformatf("mc%0d", i), 5'b00111, 5'b01000, 1'b0);
    hz.alu_op_done = 1'b1;
    cyc("mc_done", 5'b00000, 5'b00000, 1'b1);
    idle();
    check("mc/stall_cycles", hz.stall_cycles, 32'(exp_sc));
    check("mc/no_timeout", 32'(hz.timeout_err), 32'h0);

    // Watchdog: a 10-cycle D-cache miss exceeds the 8-cycle limit.
    do_reset();
    hz.dcache_req = 1'b1; hz.dcache_op_done = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc($sformatf("wd%0d", i), 5'b01111, 5'b10000, 1'b0);
      if (i == 5)  check("wd/early", 32'(hz.timeout_err), 32'h0);
      if (i == 10) check("wd/tripped", 32'(hz.timeout_err), 32'h1);
    end
    hz.dcache_op_done = 1'b1;
    cyc("wd_resolve", 5'b00000, 5'b00000, 1'b1);
    check("wd/sticky", 32'(hz.timeout_err), 32'h1);
    check("wd/stall_cycles", hz.stall_cycles, 32'd10);
    do_reset();
    check("wd/cleared", 32'(hz.timeout_err), 32'h0);

    // Reset asserted mid-wait with drop_fetch pending.
    hz.icache_op_done = 1'b0;
    cyc("mr_miss", 5'b00001, 5'b00010, 1'b0);
    hz.branch_taken = 1'b1;
    cyc("mr_branch", 5'b00000, 5'b00110, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mr/flush", 32'(hz.flush), 32'h1f);
    check("mr/stall", 32'(hz.stall), 32'h0);
    check("mr/inc_pc", 32'(hz.increase_pc), 32'h0);
    check("mr/stall_cycles", hz.stall_cycles, 32'd0);
    @(negedge clk);
    @(negedge clk);
    idle();
    rst_n  = 1'b1;
    exp_sc = 0;
    cyc("mr_after", 5'b00000, 5'b00000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
